// File: rtl/ncl_threshold_gate_array_if.sv
// Gate-array bus: per-lane NCL inputs in, registered outputs and completeness flags out.
interface ncl_threshold_gate_array_if #(
    parameter int LANES      = 1,
    parameter int NUM_INPUTS = 2
);
    logic [LANES*NUM_INPUTS-1:0] in;
    logic [LANES-1:0]            out;
    logic                        any_set;
    logic                        all_set;

    modport master (output in, input out, input any_set, input all_set);
    modport slave  (input in, output out, output any_set, output all_set);
endinterface

// File: rtl/ncl_threshold_gate_array.sv
// LANES independent clocked NCL THmn hysteresis gates: set at threshold, clear on all-NULL, else hold.
module ncl_threshold_gate_array #(
    parameter int NUM_INPUTS  = 2,
    parameter int THRESHOLD   = 2,
    parameter int LANES       = 1,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ncl_threshold_gate_array_if.slave  gate
);

    localparam int CW = $clog2(NUM_INPUTS + 1);

    if (NUM_INPUTS < 1 || NUM_INPUTS > 8) begin : g_bad_inputs
        $error("ncl_threshold_gate_array: NUM_INPUTS must be 1..8");
    end
    if (THRESHOLD < 1 || THRESHOLD > NUM_INPUTS) begin : g_bad_threshold
        $error("ncl_threshold_gate_array: THRESHOLD must be 1..NUM_INPUTS");
    end
    if (LANES < 1 || LANES > 64) begin : g_bad_lanes
        $error("ncl_threshold_gate_array: LANES must be 1..64");
    end

    logic [LANES-1:0] out_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [NUM_INPUTS-1:0] lane_in;
        logic [CW-1:0]         cnt;
        logic                  lane_q;

        assign lane_in = gate.in[k*NUM_INPUTS +: NUM_INPUTS];

        always_comb begin
            cnt = '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt = cnt + CW'(lane_in[i]);
            end
        end

        // Neither branch taken means a partial DATA/NULL wavefront: keep the old value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_q <= RESET_VALUE;
            end else if (cnt >= CW'(THRESHOLD)) begin
                lane_q <= 1'b1;
            end else if (cnt == '0) begin
                lane_q <= 1'b0;
            end
        end

        assign out_q[k] = lane_q;
    end

    assign gate.out     = out_q;
    assign gate.any_set = |out_q;
    assign gate.all_set = &out_q;

endmodule

// File: tb/tb_ncl_threshold_gate_array.sv
// Directed and randomized checks of TH22/TH12/TH14/multi-lane/D-type gate arrays against a popcount model.
module tb_ncl_threshold_gate_array;

    logic clk;
    logic rst22, rst12, rst14, rst4, rstd;
    int   n_tests = 0;
    int   n_fail  = 0;

    ncl_threshold_gate_array_if #(.LANES(1), .NUM_INPUTS(2)) if22 ();
    ncl_threshold_gate_array_if #(.LANES(1), .NUM_INPUTS(2)) if12 ();
    ncl_threshold_gate_array_if #(.LANES(1), .NUM_INPUTS(4)) if14 ();
    ncl_threshold_gate_array_if #(.LANES(4), .NUM_INPUTS(2)) if4l ();
    ncl_threshold_gate_array_if #(.LANES(1), .NUM_INPUTS(2)) ifd  ();

    ncl_threshold_gate_array #(.NUM_INPUTS(2), .THRESHOLD(2), .LANES(1), .RESET_VALUE(1'b0))
        u_th22 (.clk(clk), .rst_n(rst22), .gate(if22.slave));
    ncl_threshold_gate_array #(.NUM_INPUTS(2), .THRESHOLD(1), .LANES(1), .RESET_VALUE(1'b0))
        u_th12 (.clk(clk), .rst_n(rst12), .gate(if12.slave));
    ncl_threshold_gate_array #(.NUM_INPUTS(4), .THRESHOLD(1), .LANES(1), .RESET_VALUE(1'b0))
        u_th14 (.clk(clk), .rst_n(rst14), .gate(if14.slave));
    ncl_threshold_gate_array #(.NUM_INPUTS(2), .THRESHOLD(2), .LANES(4), .RESET_VALUE(1'b0))
        u_lanes (.clk(clk), .rst_n(rst4), .gate(if4l.slave));
    ncl_threshold_gate_array #(.NUM_INPUTS(2), .THRESHOLD(2), .LANES(1), .RESET_VALUE(1'b1))
        u_dtype (.clk(clk), .rst_n(rstd), .gate(ifd.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next output per lane from the THmn rule: count ones, compare to m, hold in between.
    function automatic logic [7:0] ncl_ref(input logic [7:0] prev, input logic [7:0] ins,
                                           input int n, input int m, input int lanes);
        logic [7:0] r;
        r = prev;
        for (int l = 0; l < lanes; l++) begin
            int c;
            c = 0;
            for (int b = 0; b < n; b++) c += int'(ins[l*n + b]);
            if (c >= m) r[l] = 1'b1;
            else if (c == 0) r[l] = 1'b0;
        end
        return r;
    endfunction

    logic [1:0] seq22 [7] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
    logic       exp22 [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] seq12 [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic       exp12 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] seq14 [5] = '{4'b0000, 4'b1000, 4'b0000, 4'b0110, 4'b0000};
    logic       exp14 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [7:0]  m22, m12, m14, m4, md;
        logic [31:0] r;

        rst22 = 1'b0; rst12 = 1'b0; rst14 = 1'b0; rst4 = 1'b0; rstd = 1'b0;
        if22.in = 2'b11; if12.in = 2'b11; if14.in = 4'hF; if4l.in = 8'hFF; ifd.in = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_th22", 8'(if22.out), 8'd0);
        chk("rst_th12", 8'(if12.out), 8'd0);
        chk("rst_th14", 8'(if14.out), 8'd0);
        chk("rst_lanes_out", 8'(if4l.out), 8'd0);
        chk("rst_lanes_any", 8'(if4l.any_set), 8'd0);
        chk("rst_lanes_all", 8'(if4l.all_set), 8'd0);
        chk("rst_dtype_00", 8'(ifd.out), 8'd1);
        ifd.in = 2'b11;
        @(negedge clk);
        chk("rst_dtype_11", 8'(ifd.out), 8'd1);

        // Directed sequences, one value per clock, checked one edge later.
        rst22 = 1'b1; rst12 = 1'b1; rst14 = 1'b1; rst4 = 1'b1;
        if22.in = seq22[0]; if12.in = seq12[0]; if14.in = seq14[0];
        if4l.in = 8'b11_00_01_11;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("th22_seq%0d", i), 8'(if22.out), 8'(exp22[i]));
            if (i < 5) begin
                chk($sformatf("th12_seq%0d", i), 8'(if12.out), 8'(exp12[i]));
                chk($sformatf("th14_seq%0d", i), 8'(if14.out), 8'(exp14[i]));
            end
            if (i == 0) begin
                chk("lanes_out_mixed", 8'(if4l.out), 8'h09);
                chk("lanes_any_mixed", 8'(if4l.any_set), 8'd1);
                chk("lanes_all_mixed", 8'(if4l.all_set), 8'd0);
                if4l.in = 8'hFF;
            end
            if (i == 1) begin
                chk("lanes_out_full", 8'(if4l.out), 8'h0F);
                chk("lanes_all_full", 8'(if4l.all_set), 8'd1);
            end
            if (i < 6) if22.in = seq22[i+1];
            if (i < 4) begin
                if12.in = seq12[i+1];
                if14.in = seq14[i+1];
            end
        end

        // Reset pulse between edges while TH22 holds 1 on a partial input.
        if22.in = 2'b11;
        @(negedge clk);
        chk("midrst_set", 8'(if22.out), 8'd1);
        if22.in = 2'b01;
        @(negedge clk);
        chk("midrst_hold1", 8'(if22.out), 8'd1);
        #2 rst22 = 1'b0;
        #1 chk("midrst_async", 8'(if22.out), 8'd0);
        #1 rst22 = 1'b1;
        @(negedge clk);
        chk("midrst_hold0", 8'(if22.out), 8'd0);
        if22.in = 2'b11;
        @(negedge clk);
        chk("midrst_reset", 8'(if22.out), 8'd1);

        // D-type release on a partial input holds 1, all-NULL clears.
        ifd.in = 2'b01;
        rstd = 1'b1;
        @(negedge clk);
        chk("dtype_release_hold", 8'(ifd.out), 8'd1);
        ifd.in = 2'b00;
        @(negedge clk);
        chk("dtype_null", 8'(ifd.out), 8'd0);

        m22 = 8'd1; m12 = 8'd0; m14 = 8'd0; m4 = 8'h0F; md = 8'd0;
        for (int t = 0; t < 300; t++) begin
            r = $urandom;
            if22.in = r[1:0];
            if12.in = r[3:2];
            if14.in = r[7:4];
            if4l.in = r[15:8];
            ifd.in  = r[17:16];
            rst4    = (r[21:18] != 4'd0);
            m22 = ncl_ref(m22, 8'(r[1:0]), 2, 2, 1);
            m12 = ncl_ref(m12, 8'(r[3:2]), 2, 1, 1);
            m14 = ncl_ref(m14, 8'(r[7:4]), 4, 1, 1);
            m4  = rst4 ? ncl_ref(m4, r[15:8], 2, 2, 4) : 8'd0;
            md  = ncl_ref(md, 8'(r[17:16]), 2, 2, 1);
            @(negedge clk);
            chk("rnd_th22", 8'(if22.out), m22);
            chk("rnd_th12", 8'(if12.out), m12);
            chk("rnd_th14", 8'(if14.out), m14);
            chk("rnd_lanes_out", 8'(if4l.out), m4);
            chk("rnd_lanes_any", 8'(if4l.any_set), 8'(m4[3:0] != 4'd0));
            chk("rnd_lanes_all", 8'(if4l.all_set), 8'(m4[3:0] == 4'hF));
            chk("rnd_dtype", 8'(ifd.out), md);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ncl_threshold_gate_array.md
Name: ncl_threshold_gate_array

Overview:
- Clocked, synthesizable model of NCL hysteresis threshold gates THmn (m of n).
- Covers TH12 (2-input OR), TH14 (4-input OR) and TH22 (2-input C-element) through parameters.
- Instantiated in LANES parallel copies, for example one lane per dual-rail rail in completeness trees, output buffers and rail-merge logic.
- Each lane follows standard NCL semantics: assert at threshold, deassert only on all-NULL, hold otherwise.

Parameters:
- NUM_INPUTS, 2: inputs per gate (n). Legal range 1..8.
- THRESHOLD, 2: assertion threshold (m). Legal range 1..NUM_INPUTS. An illegal value is an elaboration error via generate-time $error.
- LANES, 1: number of independent gate instances. Legal range 1..64.
- RESET_VALUE, 0: per-lane output value while rst_n is low. Use 0 for N-type (NULL) gates, 1 for D-type gates.

Ports:
- clk, input, 1: single clock. All state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in, input, LANES*NUM_INPUTS: gate inputs. Lane k uses in[k*NUM_INPUTS +: NUM_INPUTS]; bit 0 is gate input a.
- out, output, LANES: registered gate outputs, one per lane.
- any_set, output, 1: combinational OR of all out bits.
- all_set, output, 1: combinational AND of all out bits (completeness indicator).

Behaviour:
- Reset
  - rst_n low forces every out bit to RESET_VALUE immediately, independent of clk.
  - While rst_n is low, in is ignored.
  - Release of rst_n is synchronized by the user. The first update happens on the first rising clk edge with rst_n high.
- Per-lane update on each rising clk edge, with cnt = popcount of the lane's NUM_INPUTS bits:
  - cnt >= THRESHOLD: out becomes 1 (DATA).
  - cnt == 0: out becomes 0 (NULL).
  - Otherwise: out holds its previous value (hysteresis).
- Latency is exactly 1 clock from input change to out. No combinational path from in to out.
- Configurations:
  - THRESHOLD=1: the hold branch is unreachable, so the lane is a registered OR.
    - NUM_INPUTS=2 gives TH12.
    - NUM_INPUTS=4 gives TH14.
  - THRESHOLD=NUM_INPUTS=2 gives TH22 (Muller C-element).
    - Output rises only when both inputs are 1.
    - Output falls only when both inputs are 0.
- Popcount width is clog2(NUM_INPUTS+1) bits. Comparison is unsigned. No overflow is possible.
- Lanes are fully independent. No cross-lane coupling except any_set and all_set.
- any_set and all_set derive combinationally from registered out, so they are glitch-free with respect to in.
- Reset asserted mid-operation overrides any pending update in the same cycle. out goes to RESET_VALUE and the held state is lost.
- With RESET_VALUE=1 and all inputs 0 after reset release, out goes to 0 on the first edge.
- X on any input bit of a lane may propagate X to that lane only. Other lanes are unaffected.

Test Plan:
- TH22 (N=2, M=2, LANES=1), reset then sequence in=00,01,11,01,10,00,10 with one value per clock.
  - Required out one clock after each value: 0,0,1,1,1,0,0.
- TH12 (N=2, M=1), sequence in=00,01,10,11,00.
  - Required out: 0,1,1,1,0.
  - Hold is never exercised.
- TH14 (N=4, M=1), sequence in=0000,1000,0000,0110,0000.
  - Required out: 0,1,0,1,0.
- Reset mid-operation: TH22 with out=1 and in=01, pulse rst_n low between edges.
  - out drops to 0 immediately.
  - After release with in=01 held, out stays 0 (hold from the reset state).
  - in=11 then gives 1 on the next edge.
- Multi-lane (N=2, M=2, LANES=4), in=8'b11_00_01_11 applied from reset.
  - Required out=4'b1001, any_set=1, all_set=0.
  - Then in=8'hFF gives out=4'hF and all_set=1.
- RESET_VALUE=1, TH22, hold rst_n low.
  - out=1 regardless of in.
  - Release with in=01: out stays 1.
  - Then in=00 gives 0 on the next edge.
